// File: rtl/ni_target_resp_packetizer.sv
// Target-side network interface: turns a response header plus optional data beats
// into a source-routed flit stream, dropping responses whose initiator is unmapped.
`timescale 1ns/1ps

`ifndef SOURCEWD
`define SOURCEWD 4
`endif

module ni_target_resp_packetizer #(
    parameter int FLIT_WIDTH = 80,
    parameter int DATA_WIDTH = 64,
    parameter int PATH_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rsp_valid,
    output logic                  rsp_ready,
    input  logic [`SOURCEWD-1:0]  rsp_source,
    input  logic [1:0]            rsp_status,
    input  logic [3:0]            rsp_len,
    input  logic                  rsp_has_data,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_data_valid,
    output logic                  rsp_data_ready,
    output logic [`SOURCEWD-1:0]  lut_address,
    input  logic [PATH_WIDTH-1:0] lut_path,
    output logic [FLIT_WIDTH-1:0] flit_out,
    output logic                  flit_valid,
    input  logic                  flit_stall,
    output logic                  route_err
);

    localparam int SW        = `SOURCEWD;
    localparam int STATUS_LO = PATH_WIDTH + SW;
    localparam int LEN_LO    = STATUS_LO + 2;
    localparam int HASD_BIT  = LEN_LO + 4;
    localparam int HEAD_BIT  = FLIT_WIDTH - 1;
    localparam int TAIL_BIT  = FLIT_WIDTH - 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROUTE  = 3'd1,
        HEADER = 3'd2,
        BODY   = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           source_q, source_d;
    logic [1:0]              status_q, status_d;
    logic [3:0]              len_q, len_d;
    logic                    has_data_q, has_data_d;
    logic [PATH_WIDTH-1:0]   path_q, path_d;
    logic [3:0]              beat_q, beat_d;

    logic                    rsp_ready_s;
    logic                    rsp_data_ready_s;
    logic                    flit_valid_s;
    logic                    route_err_s;
    logic [FLIT_WIDTH-1:0]   flit_s;
    logic                    last_beat_s;

    assign last_beat_s = (beat_q == len_q);

    // Packet sequencing: next state, captured header fields, beat count, raw outputs.
    always_comb begin
        state_d          = state_q;
        source_d         = source_q;
        status_d         = status_q;
        len_d            = len_q;
        has_data_d       = has_data_q;
        path_d           = path_q;
        beat_d           = beat_q;
        rsp_ready_s      = 1'b0;
        rsp_data_ready_s = 1'b0;
        flit_valid_s     = 1'b0;
        route_err_s      = 1'b0;
        flit_s           = '0;

        case (state_q)
            IDLE: begin
                rsp_ready_s = 1'b1;
                if (rsp_valid) begin
                    source_d   = rsp_source;
                    status_d   = rsp_status;
                    len_d      = rsp_len;
                    has_data_d = rsp_has_data;
                    state_d    = ROUTE;
                end else begin
                    state_d = IDLE;
                end
            end
            ROUTE: begin
                path_d = lut_path;
                if (lut_path != '0) begin
                    state_d = HEADER;
                end else begin
                    // Unmapped initiator: the data beats still have to be consumed.
                    route_err_s = 1'b1;
                    beat_d      = 4'd0;
                    state_d     = has_data_q ? DRAIN : IDLE;
                end
            end
            HEADER: begin
                flit_valid_s                  = 1'b1;
                flit_s[PATH_WIDTH-1:0]        = path_q;
                flit_s[PATH_WIDTH +: SW]      = source_q;
                flit_s[STATUS_LO +: 2]        = status_q;
                flit_s[LEN_LO +: 4]           = len_q;
                flit_s[HASD_BIT]              = has_data_q;
                flit_s[HEAD_BIT]              = 1'b1;
                flit_s[TAIL_BIT]              = ~has_data_q;
                if (!flit_stall) begin
                    beat_d  = 4'd0;
                    state_d = has_data_q ? BODY : IDLE;
                end else begin
                    state_d = HEADER;
                end
            end
            BODY: begin
                flit_valid_s     = rsp_data_valid;
                rsp_data_ready_s = ~flit_stall;
                if (rsp_data_valid) begin
                    flit_s[DATA_WIDTH-1:0] = rsp_data;
                    flit_s[TAIL_BIT]       = last_beat_s;
                end else begin
                    flit_s = '0;
                end
                if (rsp_data_valid && !flit_stall) begin
                    if (last_beat_s) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end else begin
                    state_d = BODY;
                end
            end
            DRAIN: begin
                rsp_data_ready_s = 1'b1;
                if (rsp_data_valid) begin
                    if (last_beat_s) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 4'd1;
                    end
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are held quiet for the whole time reset is high, not just after the edge.
    always_comb begin
        if (reset) begin
            rsp_ready      = 1'b0;
            rsp_data_ready = 1'b0;
            flit_valid     = 1'b0;
            route_err      = 1'b0;
            flit_out       = '0;
            lut_address    = '0;
        end else begin
            rsp_ready      = rsp_ready_s;
            rsp_data_ready = rsp_data_ready_s;
            flit_valid     = flit_valid_s;
            route_err      = route_err_s;
            flit_out       = flit_s;
            lut_address    = source_q;
        end
    end

    // State and captured header registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            source_q   <= '0;
            status_q   <= 2'b00;
            len_q      <= 4'd0;
            has_data_q <= 1'b0;
            path_q     <= '0;
            beat_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            source_q   <= source_d;
            status_q   <= status_d;
            len_q      <= len_d;
            has_data_q <= has_data_d;
            path_q     <= path_d;
            beat_q     <= beat_d;
        end
    end

endmodule

// File: tb/tb_ni_target_resp_packetizer.sv
// Directed bench for ni_target_resp_packetizer: hand-computed header and body flits,
// stall, unroutable drain and mid-packet reset.
`timescale 1ns/1ps

`ifndef SOURCEWD
`define SOURCEWD 4
`endif

module tb_ni_target_resp_packetizer;

    logic        clock = 1'b0;
    logic        reset;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_source;
    logic [1:0]  rsp_status;
    logic [3:0]  rsp_len;
    logic        rsp_has_data;
    logic [63:0] rsp_data;
    logic        rsp_data_valid;
    logic        rsp_data_ready;
    logic [3:0]  lut_address;
    logic [6:0]  lut_path;
    logic [79:0] flit_out;
    logic        flit_valid;
    logic        flit_stall;
    logic        route_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    ni_target_resp_packetizer #(
        .FLIT_WIDTH(80),
        .DATA_WIDTH(64),
        .PATH_WIDTH(7)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_source     (rsp_source),
        .rsp_status     (rsp_status),
        .rsp_len        (rsp_len),
        .rsp_has_data   (rsp_has_data),
        .rsp_data       (rsp_data),
        .rsp_data_valid (rsp_data_valid),
        .rsp_data_ready (rsp_data_ready),
        .lut_address    (lut_address),
        .lut_path       (lut_path),
        .flit_out       (flit_out),
        .flit_valid     (flit_valid),
        .flit_stall     (flit_stall),
        .route_err      (route_err)
    );

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the rising edge. Check point: the falling edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        @(negedge clock);
    endtask

    // Presents a header in IDLE, checks the accept cycle and the ROUTE cycle.
    // Returns just after the edge that leaves ROUTE.
    task automatic send_hdr(input logic [3:0] src, input logic [1:0] st, input logic [3:0] len,
                            input logic hd, input logic [6:0] path);
        rsp_source   = src;
        rsp_status   = st;
        rsp_len      = len;
        rsp_has_data = hd;
        lut_path     = path;
        rsp_valid    = 1'b1;
        settle();
        check_eq("idle_rsp_ready", 80'(rsp_ready), 80'd1);
        tick();
        rsp_valid = 1'b0;
        settle();
        check_eq("route_lut_address", 80'(lut_address), 80'(src));
        check_eq("route_rsp_ready", 80'(rsp_ready), 80'd0);
        check_eq("route_flit_valid", 80'(flit_valid), 80'd0);
        check_eq("route_data_ready", 80'(rsp_data_ready), 80'd0);
        check_eq("route_err_pulse", 80'(route_err), (path == 7'd0) ? 80'd1 : 80'd0);
        tick();
    endtask

    // Body of a len-3 read carrying data 1..4, optionally stalling two cycles on one beat.
    task automatic read_body(input int stall_beat);
        for (int b = 1; b <= 4; b++) begin
            if (b == stall_beat) begin
                flit_stall = 1'b1;
                for (int s = 0; s < 2; s++) begin
                    settle();
                    check_eq("stall_flit_valid", 80'(flit_valid), 80'd1);
                    check_eq("stall_flit_hold", flit_out, 80'(b));
                    check_eq("stall_data_ready", 80'(rsp_data_ready), 80'd0);
                    tick();
                end
                flit_stall = 1'b0;
            end
            settle();
            check_eq("body_flit_valid", 80'(flit_valid), 80'd1);
            check_eq("body_flit", flit_out,
                     (b == 4) ? (80'h40000000000000000000 | 80'(b)) : 80'(b));
            check_eq("body_data_ready", 80'(rsp_data_ready), 80'd1);
            tick();
            rsp_data = 64'(b + 1);
            if (b == 4) begin
                rsp_data_valid = 1'b0;
            end
        end
        settle();
        check_eq("post_body_rsp_ready", 80'(rsp_ready), 80'd1);
        check_eq("post_body_flit_valid", 80'(flit_valid), 80'd0);
        check_eq("post_body_flit_zero", flit_out, 80'd0);
        check_eq("post_body_data_ready", 80'(rsp_data_ready), 80'd0);
        tick();
    endtask

    task automatic write_ack_3();
        send_hdr(4'h3, 2'b00, 4'd0, 1'b0, 7'b0000001);
        settle();
        check_eq("wack_flit_valid", 80'(flit_valid), 80'd1);
        check_eq("wack_header", flit_out, 80'hC0000000000000000181);
        tick();
        settle();
        check_eq("wack_done_flit_valid", 80'(flit_valid), 80'd0);
        check_eq("wack_done_rsp_ready", 80'(rsp_ready), 80'd1);
        check_eq("wack_done_flit_zero", flit_out, 80'd0);
        tick();
    endtask

    task automatic read_header_d();
        rsp_data_valid = 1'b1;
        rsp_data       = 64'd1;
        send_hdr(4'hd, 2'b01, 4'd3, 1'b1, 7'b0000011);
        settle();
        check_eq("read_flit_valid", 80'(flit_valid), 80'd1);
        check_eq("read_header", flit_out, 80'h80000000000000026E83);
        check_eq("read_hdr_data_ready", 80'(rsp_data_ready), 80'd0);
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        rsp_valid      = 1'b0;
        rsp_source     = 4'h0;
        rsp_status     = 2'b00;
        rsp_len        = 4'd0;
        rsp_has_data   = 1'b0;
        rsp_data       = 64'd0;
        rsp_data_valid = 1'b0;
        lut_path       = 7'd0;
        flit_stall     = 1'b0;

        tick();
        tick();
        settle();
        check_eq("rst_rsp_ready", 80'(rsp_ready), 80'd0);
        check_eq("rst_flit_valid", 80'(flit_valid), 80'd0);
        check_eq("rst_lut_address", 80'(lut_address), 80'd0);
        tick();
        reset = 1'b0;
        settle();
        check_eq("post_rst_rsp_ready", 80'(rsp_ready), 80'd1);
        check_eq("post_rst_lut_address", 80'(lut_address), 80'd0);
        tick();

        // Write ack, single head+tail flit two cycles after accept.
        write_ack_3();

        // Read of four beats without and with a two-cycle stall on beat 2.
        read_header_d();
        read_body(0);
        read_header_d();
        read_body(2);

        // Unroutable read: error pulse, two beats swallowed, nothing emitted.
        rsp_data_valid = 1'b1;
        rsp_data       = 64'hAA;
        send_hdr(4'h0, 2'b00, 4'd1, 1'b1, 7'd0);
        settle();
        check_eq("drain_err_cleared", 80'(route_err), 80'd0);
        check_eq("drain_flit_valid0", 80'(flit_valid), 80'd0);
        check_eq("drain_flit_zero", flit_out, 80'd0);
        check_eq("drain_data_ready0", 80'(rsp_data_ready), 80'd1);
        tick();
        settle();
        check_eq("drain_flit_valid1", 80'(flit_valid), 80'd0);
        check_eq("drain_data_ready1", 80'(rsp_data_ready), 80'd1);
        tick();
        rsp_data_valid = 1'b0;
        settle();
        check_eq("drain_done_rsp_ready", 80'(rsp_ready), 80'd1);
        check_eq("drain_done_data_ready", 80'(rsp_data_ready), 80'd0);
        tick();

        // Write ack to source 9 with a multi-bit path.
        send_hdr(4'h9, 2'b10, 4'd0, 1'b0, 7'b0011100);
        settle();
        check_eq("src9_header", flit_out, 80'hC000000000000000149C);
        check_eq("src9_lut_address", 80'(lut_address), 80'h9);
        tick();
        settle();
        check_eq("src9_done_rsp_ready", 80'(rsp_ready), 80'd1);
        tick();

        // Reset after the first body beat of a read.
        read_header_d();
        settle();
        check_eq("mid_beat1", flit_out, 80'd1);
        tick();
        reset    = 1'b1;
        rsp_data = 64'd2;
        settle();
        check_eq("mid_rst_rsp_ready", 80'(rsp_ready), 80'd0);
        check_eq("mid_rst_data_ready", 80'(rsp_data_ready), 80'd0);
        check_eq("mid_rst_flit_valid", 80'(flit_valid), 80'd0);
        check_eq("mid_rst_flit_zero", flit_out, 80'd0);
        check_eq("mid_rst_route_err", 80'(route_err), 80'd0);
        check_eq("mid_rst_lut_address", 80'(lut_address), 80'd0);
        tick();
        reset          = 1'b0;
        rsp_data_valid = 1'b0;
        settle();
        check_eq("after_rst_rsp_ready", 80'(rsp_ready), 80'd1);
        check_eq("after_rst_flit_valid", 80'(flit_valid), 80'd0);
        check_eq("after_rst_lut_address", 80'(lut_address), 80'd0);
        tick();
        write_ack_3();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
